// File: rtl/scan_decoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : scan_decoder_pkg
// Description : Shared types and helpers for the scan decoder: FSM state
//               encoding and the decoder line encoding function.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int c_MAX_SEL_W = 6;
    localparam int c_MAX_OUT_W = 64;

    // Full-width line pattern for index idx; callers truncate to their width.
    function automatic logic [c_MAX_OUT_W-1:0] onehot(
        input logic [c_MAX_SEL_W-1:0] idx,
        input logic                   active_low
    );
        logic [c_MAX_OUT_W-1:0] w_line;
        w_line = {{(c_MAX_OUT_W-1){1'b0}}, 1'b1} << idx;
        return active_low ? ~w_line : w_line;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_prescaler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : scan_prescaler
// Description : Programmable divider producing one tick every div+1 enabled
//               cycles. The count compares with >= so lowering div below the
//               running count ticks on the very next cycle.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               clr  - synchronous clear of the count (suppresses tick)
//               en   - count enable
//               div  - divide value (tick period = div+1)
//               tick - combinational tick, valid in the cycle it is due
// Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;
    logic             w_due;

    assign w_due = (r_count >= div);
    assign tick  = en && !clr && w_due;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en) begin
            if (w_due) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + DIV_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : scan_decoder
// Description : Registered N-to-2**N line decoder with direct-select and
//               auto-scan modes, programmable scan rate and direction.
// Ports       : clk      - clock (rising edge)
//               rst      - synchronous active-high reset
//               en_n     - active-low enable; high forces all lines inactive
//               mode     - 0 direct decode of sel, 1 auto-scan
//               sel      - direct select / scan load value
//               load     - scan-mode strobe copying sel into the index
//               dir      - scan direction, 0 up, 1 down
//               tick_div - scan steps once every tick_div+1 cycles
//               dec_out  - registered decoder lines (polarity per ACTIVE_LOW)
//               idx      - registered index currently decoded
//               active   - high when exactly one line is asserted
//               wrap     - one-cycle pulse when the scan index wraps
// Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int ACTIVE_LOW = 1,
    parameter int DIV_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic                    dir,
    input  logic [DIV_W-1:0]        tick_div,
    output logic [(2**SEL_W)-1:0]   dec_out,
    output logic [SEL_W-1:0]        idx,
    output logic                    active,
    output logic                    wrap
);

    localparam int               OUT_W      = 2**SEL_W;
    localparam logic [OUT_W-1:0] c_INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [SEL_W-1:0] c_IDX_MAX  = {SEL_W{1'b1}};

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_scan;
    logic                    w_entry;
    logic                    w_load;
    logic                    w_clr;
    logic                    w_tick;
    logic [SEL_W-1:0]        w_idx_d;
    logic [c_MAX_SEL_W-1:0]  w_idx_ext;
    logic [OUT_W-1:0]        w_dec_d;
    logic                    w_active_d;
    logic                    w_wrap_d;

    // Next state and prescaler control. The state is re-decided every cycle
    // from en_n/mode; r_state only remembers it to detect SCAN entry.
    always_comb begin
        w_next_state = ST_IDLE;
        if (!en_n) begin
            w_next_state = mode ? ST_SCAN : ST_DIRECT;
        end
        w_scan  = (w_next_state == ST_SCAN);
        w_entry = w_scan && (r_state != ST_SCAN);
        w_load  = w_scan && load;
        // Outside SCAN the prescaler is held at zero, so entry restarts it.
        w_clr   = !w_scan || w_entry || w_load;
    end

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_scan),
        .div  (tick_div),
        .tick (w_tick)
    );

    // Next output values; a load has priority over a due step and never wraps.
    always_comb begin
        w_idx_d    = idx;
        w_active_d = 1'b0;
        w_wrap_d   = 1'b0;
        case (w_next_state)
            ST_DIRECT: begin
                w_idx_d    = sel;
                w_active_d = 1'b1;
            end
            ST_SCAN: begin
                w_active_d = 1'b1;
                if (w_load) begin
                    w_idx_d = sel;
                end else if (w_tick) begin
                    if (dir) begin
                        w_idx_d  = idx - SEL_W'(1);
                        w_wrap_d = (idx == '0);
                    end else begin
                        w_idx_d  = idx + SEL_W'(1);
                        w_wrap_d = (idx == c_IDX_MAX);
                    end
                end
            end
            default: begin
                w_idx_d = idx;
            end
        endcase

        w_idx_ext              = '0;
        w_idx_ext[SEL_W-1:0]   = w_idx_d;
        w_dec_d                = c_INACTIVE;
        if (w_active_d) begin
            w_dec_d = OUT_W'(onehot(w_idx_ext, ACTIVE_LOW != 0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            idx     <= '0;
            dec_out <= c_INACTIVE;
            active  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            idx     <= w_idx_d;
            dec_out <= w_dec_d;
            active  <= w_active_d;
            wrap    <= w_wrap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_scan_decoder
// Description : Scoreboard bench for scan_decoder. Unit A is SEL_W=2 with
//               active-low lines, unit B is SEL_W=3 with active-high lines.
//               Stimulus queues the expected outputs after the next edge; a
//               monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       a_en_n, a_mode, a_load, a_dir;
    logic [1:0] a_sel;
    logic [7:0] a_div;
    logic [3:0] a_dec;
    logic [1:0] a_idx;
    logic       a_active, a_wrap;

    logic       b_en_n, b_mode, b_load, b_dir;
    logic [2:0] b_sel;
    logic [7:0] b_div;
    logic [7:0] b_dec;
    logic [2:0] b_idx;
    logic       b_active, b_wrap;

    scan_decoder #(.SEL_W(2), .ACTIVE_LOW(1), .DIV_W(8)) u_a (
        .clk(clk), .rst(rst), .en_n(a_en_n), .mode(a_mode), .sel(a_sel),
        .load(a_load), .dir(a_dir), .tick_div(a_div),
        .dec_out(a_dec), .idx(a_idx), .active(a_active), .wrap(a_wrap)
    );

    scan_decoder #(.SEL_W(3), .ACTIVE_LOW(0), .DIV_W(8)) u_b (
        .clk(clk), .rst(rst), .en_n(b_en_n), .mode(b_mode), .sel(b_sel),
        .load(b_load), .dir(b_dir), .tick_div(b_div),
        .dec_out(b_dec), .idx(b_idx), .active(b_active), .wrap(b_wrap)
    );

    typedef struct {
        string      name;
        bit         unit;
        logic [7:0] dec;
        logic [2:0] idx;
        logic       act;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Hand-derived idx sequence for tick_div=2 up-scan, edges 1..12 after entry.
    localparam logic [1:0] UP_IDX [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                           2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    localparam logic [3:0] A_DEC [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic expect_a(input string nm, input logic [3:0] dec,
                            input logic [1:0] i, input logic act, input logic wr);
        exp_t e;
        e.name = nm; e.unit = 1'b0; e.dec = {4'b0000, dec}; e.idx = {1'b0, i};
        e.act = act; e.wrap = wr;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic expect_b(input string nm, input logic [7:0] dec,
                            input logic [2:0] i, input logic act, input logic wr);
        exp_t e;
        e.name = nm; e.unit = 1'b1; e.dec = dec; e.idx = i;
        e.act = act; e.wrap = wr;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compares the outputs registered at each rising edge.
    exp_t       m;
    logic [7:0] g_dec;
    logic [2:0] g_idx;
    logic       g_act, g_wrap, ok;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                m = q.pop_front();
                if (m.unit == 1'b0) begin
                    g_dec = {4'b0000, a_dec}; g_idx = {1'b0, a_idx};
                    g_act = a_active;         g_wrap = a_wrap;
                end else begin
                    g_dec = b_dec;    g_idx = b_idx;
                    g_act = b_active; g_wrap = b_wrap;
                end
                ok = (g_dec === m.dec) && (g_idx === m.idx) &&
                     (g_act === m.act) && (g_wrap === m.wrap);
                if (m.unit == 1'b1 && m.act == 1'b1 && $countones(g_dec) != 1) ok = 1'b0;
                n_total++;
                if (ok) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got dec=%b idx=%0d active=%b wrap=%b, want dec=%b idx=%0d active=%b wrap=%b",
                             m.name, g_dec, g_idx, g_act, g_wrap, m.dec, m.idx, m.act, m.wrap);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_en_n = 1'b1; a_mode = 1'b0; a_load = 1'b0; a_dir = 1'b0; a_sel = 2'd0; a_div = 8'd0;
        b_en_n = 1'b1; b_mode = 1'b0; b_load = 1'b0; b_dir = 1'b0; b_sel = 3'd0; b_div = 8'd0;
        @(negedge clk);
        expect_a("reset", 4'b1111, 2'd0, 1'b0, 1'b0);

        // Direct decode, one cycle latency.
        rst = 1'b0; a_en_n = 1'b0;
        for (int s = 0; s < 4; s++) begin
            a_sel = 2'(s);
            expect_a($sformatf("direct sel%0d", s), A_DEC[s], 2'(s), 1'b1, 1'b0);
        end

        // Disabled: all inactive, idx held, load/mode ignored.
        a_en_n = 1'b1; a_sel = 2'd2;
        expect_a("disabled sel2", 4'b1111, 2'd3, 1'b0, 1'b0);
        a_load = 1'b1; a_mode = 1'b1; a_sel = 2'd0;
        expect_a("disabled load", 4'b1111, 2'd3, 1'b0, 1'b0);

        // Up-scan, tick_div=2, from idx 0.
        a_load = 1'b0; a_mode = 1'b0; a_en_n = 1'b0; a_sel = 2'd0; a_div = 8'd2;
        expect_a("direct start0", 4'b1110, 2'd0, 1'b1, 1'b0);
        a_mode = 1'b1;
        expect_a("scan entry", 4'b1110, 2'd0, 1'b1, 1'b0);
        for (int k = 0; k < 12; k++) begin
            expect_a($sformatf("scan up edge%0d", k + 1), A_DEC[UP_IDX[k]], UP_IDX[k],
                     1'b1, (k == 11) ? 1'b1 : 1'b0);
        end

        // Down-scan every cycle from idx 0.
        a_dir = 1'b1; a_div = 8'd0;
        expect_a("scan down 0->3", 4'b0111, 2'd3, 1'b1, 1'b1);
        expect_a("scan down 3->2", 4'b1011, 2'd2, 1'b1, 1'b0);
        expect_a("scan down 2->1", 4'b1101, 2'd1, 1'b1, 1'b0);
        expect_a("scan down 1->0", 4'b1110, 2'd0, 1'b1, 1'b0);

        // Load on the cycle a step is due.
        a_dir = 1'b0; a_div = 8'd2;
        expect_a("pre-load 1", 4'b1110, 2'd0, 1'b1, 1'b0);
        expect_a("pre-load 2", 4'b1110, 2'd0, 1'b1, 1'b0);
        a_load = 1'b1; a_sel = 2'd2;
        expect_a("load beats step", 4'b1011, 2'd2, 1'b1, 1'b0);
        a_load = 1'b0;
        expect_a("post-load 1", 4'b1011, 2'd2, 1'b1, 1'b0);
        expect_a("post-load 2", 4'b1011, 2'd2, 1'b1, 1'b0);
        expect_a("post-load step", 4'b0111, 2'd3, 1'b1, 1'b0);

        // Lowering tick_div below the running count steps next cycle.
        a_div = 8'd5;
        expect_a("slow 1", 4'b0111, 2'd3, 1'b1, 1'b0);
        expect_a("slow 2", 4'b0111, 2'd3, 1'b1, 1'b0);
        expect_a("slow 3", 4'b0111, 2'd3, 1'b1, 1'b0);
        a_div = 8'd1;
        expect_a("lowered div wrap", 4'b1110, 2'd0, 1'b1, 1'b1);

        // SCAN -> DIRECT -> SCAN resumes from the direct index.
        a_mode = 1'b0; a_sel = 2'd1;
        expect_a("direct detour", 4'b1101, 2'd1, 1'b1, 1'b0);
        a_mode = 1'b1;
        expect_a("rescan entry", 4'b1101, 2'd1, 1'b1, 1'b0);
        expect_a("rescan hold", 4'b1101, 2'd1, 1'b1, 1'b0);
        expect_a("rescan step", 4'b1011, 2'd2, 1'b1, 1'b0);

        // Reset during scan.
        rst = 1'b1;
        expect_a("reset in scan", 4'b1111, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        expect_a("scan after reset", 4'b1110, 2'd0, 1'b1, 1'b0);
        a_en_n = 1'b1;

        // Unit B: 3-bit select, active-high lines, full up-scan.
        expect_b("B idle", 8'h00, 3'd0, 1'b0, 1'b0);
        b_en_n = 1'b0; b_mode = 1'b1; b_div = 8'd0;
        expect_b("B entry", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
        expect_b("B idx1", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
        expect_b("B idx2", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
        expect_b("B idx3", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        expect_b("B idx4", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
        expect_b("B idx5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
        expect_b("B idx6", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
        expect_b("B idx7", 8'b1000_0000, 3'd7, 1'b1, 1'b0);
        expect_b("B wrap", 8'b0000_0001, 3'd0, 1'b1, 1'b1);

        if (q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 2, giving select width (1..6).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1; 1 means an asserted decoder line is 0, 0 means an asserted line is 1.
REQ-003 SHALL have parameter DIV_W, default 8, giving scan prescaler width; OUT_W = 2**SEL_W is derived, not overridable.
REQ-004 SHALL have port clk, input, 1 bit, the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset, synchronous, active-high.
REQ-006 SHALL have port en_n, input, 1 bit, enable, active-low; high forces every line inactive.
REQ-007 SHALL have port mode, input, 1 bit, 0 = direct decode of sel, 1 = auto-scan.
REQ-008 SHALL have port sel, input, SEL_W bits, direct-mode select and scan start index.
REQ-009 SHALL have port load, input, 1 bit, scan-mode strobe that copies sel into the scan index.
REQ-010 SHALL have port dir, input, 1 bit, scan direction, 0 = up, 1 = down.
REQ-011 SHALL have port tick_div, input, DIV_W bits; the scan advances once every tick_div+1 cycles.
REQ-012 SHALL have port dec_out, output, OUT_W bits, registered one-hot decoder lines, polarity per ACTIVE_LOW.
REQ-013 SHALL have port idx, output, SEL_W bits, registered index currently decoded.
REQ-014 SHALL have port active, output, 1 bit, high when exactly one line is asserted.
REQ-015 SHALL have port wrap, output, 1 bit, one-cycle pulse on a scan index wrap.

Function
REQ-016 SHALL implement FSM states IDLE, DIRECT, SCAN, evaluated every cycle in this priority: en_n=1 -> IDLE; else mode=0 -> DIRECT; else SCAN.
REQ-017 SHALL, in IDLE, drive dec_out all-inactive (all ones if ACTIVE_LOW=1), active=0, wrap=0; it SHALL hold idx and clear the prescaler.
REQ-018 SHALL, in DIRECT, register idx<=sel and assert only line sel, with one cycle latency from sel to dec_out.
REQ-019 SHALL, on entry to SCAN, hold idx and clear the prescaler, so the first advance occurs tick_div+1 cycles later.
REQ-020 SHALL, in SCAN, count the prescaler up and, when count >= tick_div, clear it and step idx by +1 (dir=0) or -1 (dir=1) modulo OUT_W.
REQ-021 SHALL pulse wrap for the cycle dec_out shows the new index, on a step OUT_W-1 -> 0 (up) or 0 -> OUT_W-1 (down).
REQ-022 SHALL, when load=1 in SCAN, set idx<=sel and clear the prescaler; load SHALL beat a same-cycle advance and SHALL suppress wrap.
REQ-023 SHALL ignore load outside SCAN.
REQ-024 SHALL, with tick_div=0, step every cycle.
REQ-025 SHALL, if tick_div is lowered below the current count, step on the next cycle (>= compare, no missed wrap of the counter).
REQ-026 SHALL, when switching SCAN -> DIRECT -> SCAN, resume scanning from the last direct idx.
REQ-027 SHALL apply a dir change from the next step onward, without disturbing the prescaler.
REQ-028 SHALL keep dec_out, idx, active and wrap all registered, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE and set idx=0, prescaler=0, dec_out all-inactive, active=0, wrap=0.
REQ-030 SHALL let rst override en_n, mode, load and any in-progress scan, and SHALL make no decision in the reset cycle.

Structure
REQ-031 SHALL place the FSM state enum and an onehot(idx, ACTIVE_LOW) line-encoding function in package scan_decoder_pkg.
REQ-032 SHALL implement the prescaler as sub-module scan_prescaler (clk, rst, clr, en, div -> tick), DIV_W-parametrised.

Verification
REQ-033 SHALL check, with SEL_W=2, ACTIVE_LOW=1, en_n=0, mode=0: sel=0,1,2,3 -> dec_out 1110,1101,1011,0111, each one cycle after sel.
REQ-034 SHALL check: en_n=1 with any sel -> dec_out=1111, active=0; rst during SCAN -> next cycle idx=0, dec_out=1111.
REQ-035 SHALL check: mode=1, tick_div=2, dir=0, start idx=0 -> idx 1,2,3,0 every 3 cycles, with wrap pulsing once at the 3->0 step.
REQ-036 SHALL check: dir=1, tick_div=0 from idx=0 -> idx 3,2,1,0 on consecutive cycles, with wrap at 0->3.
REQ-037 SHALL check: load=1 with sel=2 on the cycle a step is due -> idx=2, wrap=0, next step 3 cycles later (tick_div=2).
REQ-038 SHALL check, with SEL_W=3, ACTIVE_LOW=0: a full up-scan visits all 8 one-hot codes in order, with exactly one bit high each cycle.
